// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the serial sequence generator.
//   state_t          : FSM state encoding (2 bits)
//   DEFAULT_N        : default pattern width
//   DEFAULT_PATTERN  : default pattern (110)
//   clog2_min1       : ceil(log2(v)) with a 1-bit floor for counter sizing
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_N       = 3;
  localparam logic [2:0]  DEFAULT_PATTERN = 3'b110;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sequence_generator_if.sv
// Request/stream bundle of the sequence generator.
//   start       : request, sampled only while the generator is idle
//   pattern_in  : N-bit pattern, captured on an accepted start
//   repeat_cnt  : frame count, captured on an accepted start
//   x           : serial data, MSB first
//   valid       : x carries a pattern bit
//   frame_start : pulse on the first bit of each frame
//   busy        : transfer in progress
//   done        : pulse after the last frame
// master drives the request side, slave is the generator.
interface sequence_generator_if #(
  parameter int unsigned N        = 3,
  parameter int unsigned REPEAT_W = 4
);
  logic                start;
  logic [N-1:0]        pattern_in;
  logic [REPEAT_W-1:0] repeat_cnt;
  logic                x;
  logic                valid;
  logic                frame_start;
  logic                busy;
  logic                done;

  modport master (
    output start, pattern_in, repeat_cnt,
    input  x, valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern_in, repeat_cnt,
    output x, valid, frame_start, busy, done
  );
endinterface

// File: rtl/sequence_generator_piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears the register
//   load  : load din (takes priority over shift)
//   shift : shift left by one, filling with 0
//   din   : parallel load data
//   msb   : registered MSB (serial output)
module piso_shift_reg #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         msb
);

  logic [N-1:0] sr;
  logic [N-1:0] sr_next;

  always_comb begin
    sr_next = sr;
    if (load) begin
      sr_next = din;
    end else if (shift) begin
      sr_next = sr << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= sr_next;
    end
  end

  assign msb = sr[N-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter. Sends a captured N-bit pattern MSB first,
// repeat_cnt times, with GAP idle cycles between frames. All outputs are flops.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : sequence_generator_if slave (start/pattern_in/repeat_cnt in,
//           x/valid/frame_start/busy/done out)
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int unsigned N        = DEFAULT_N,
  parameter int unsigned REPEAT_W = 4,
  parameter int unsigned GAP      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_generator_if.slave  bus
);

  localparam int unsigned BW = clog2_min1(N);
  localparam int unsigned GW = clog2_min1(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t              state, state_n;
  logic [BW-1:0]       bit_cnt, bit_n;
  logic [GW-1:0]       gap_cnt, gap_n;
  logic [REPEAT_W-1:0] frame_cnt, frame_n;
  logic [N-1:0]        pattern_r, pattern_n;

  logic                sr_load, sr_shift;
  logic [N-1:0]        sr_din;

  logic                valid_q, valid_n;
  logic                frame_start_q, frame_start_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                x_q;

  // The shift register fills with zeros, so once the last bit of a frame has
  // been shifted out its MSB is 0 and serves directly as the registered x.
  piso_shift_reg #(.N(N)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (x_q)
  );

  // State and counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      frame_cnt     <= '0;
      pattern_r     <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_n;
      gap_cnt       <= gap_n;
      frame_cnt     <= frame_n;
      pattern_r     <= pattern_n;
      valid_q       <= valid_n;
      frame_start_q <= frame_start_n;
      busy_q        <= busy_n;
      done_q        <= done_n;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_n   = state;
    bit_n     = bit_cnt;
    gap_n     = gap_cnt;
    frame_n   = frame_cnt;
    pattern_n = pattern_r;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = pattern_r;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          pattern_n = bus.pattern_in;
          frame_n   = bus.repeat_cnt;
          bit_n     = '0;
          gap_n     = '0;
          if (bus.repeat_cnt == '0) begin
            state_n = ST_FINISH;
          end else begin
            state_n = ST_SHIFT;
            sr_load = 1'b1;
            sr_din  = bus.pattern_in;
          end
        end
      end

      ST_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          frame_n = frame_cnt - 1'b1;
          bit_n   = '0;
          if (frame_n != '0) begin
            if (GAP > 0) begin
              state_n  = ST_GAP;
              gap_n    = '0;
              sr_shift = 1'b1;
            end else begin
              // Back-to-back: reload so the next MSB appears in the next cycle
              state_n = ST_SHIFT;
              sr_load = 1'b1;
            end
          end else begin
            state_n  = ST_FINISH;
            sr_shift = 1'b1;
          end
        end else begin
          bit_n    = bit_cnt + 1'b1;
          sr_shift = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = ST_SHIFT;
          gap_n   = '0;
          sr_load = 1'b1;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end

      ST_FINISH: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output logic: values for the cycle after this edge, registered above
  always_comb begin
    valid_n       = (state_n == ST_SHIFT);
    frame_start_n = (state_n == ST_SHIFT) && (bit_n == '0);
    busy_n        = (state_n == ST_SHIFT) || (state_n == ST_GAP);
    done_n        = (state_n == ST_FINISH);
  end

  assign bus.x           = x_q;
  assign bus.valid       = valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator. Expected per-cycle output
// vectors {x, valid, frame_start, busy, done} are queued when a request is
// driven and popped/compared one per cycle. Two instances: GAP=1 and GAP=0.
module tb_sequence_generator;
  import sequence_generator_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned RW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sequence_generator_if #(.N(N), .REPEAT_W(RW)) bus1 ();
  sequence_generator_if #(.N(N), .REPEAT_W(RW)) bus0 ();

  sequence_generator #(.N(N), .REPEAT_W(RW), .GAP(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  sequence_generator #(.N(N), .REPEAT_W(RW), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int errors = 0;
  int checks = 0;
  logic [4:0] expq[$];

  // Loopback "110" detectors on each x line
  logic       det_clear = 1'b1;
  logic [2:0] hist1, hist0;
  int         det1, det0;
  always @(posedge clk) begin
    if (det_clear) begin
      hist1 <= '0; hist0 <= '0; det1 <= 0; det0 <= 0;
    end else begin
      hist1 <= {hist1[1:0], bus1.x};
      hist0 <= {hist0[1:0], bus0.x};
      if ({hist1[1:0], bus1.x} == 3'b110) det1 <= det1 + 1;
      if ({hist0[1:0], bus0.x} == 3'b110) det0 <= det0 + 1;
    end
  end

  function automatic logic [4:0] obs1();
    return {bus1.x, bus1.valid, bus1.frame_start, bus1.busy, bus1.done};
  endfunction
  function automatic logic [4:0] obs0();
    return {bus0.x, bus0.valid, bus0.frame_start, bus0.busy, bus0.done};
  endfunction

  // Expected stream starting in the cycle after the start edge
  function automatic void push_frames(input logic [N-1:0] pat, input int unsigned rep,
                                      input int unsigned gap);
    for (int unsigned f = 0; f < rep; f++) begin
      for (int unsigned i = 0; i < N; i++) begin
        expq.push_back({pat[N-1-i], 1'b1, (i == 0), 1'b1, 1'b0});
      end
      if (f + 1 < rep) begin
        for (int unsigned g = 0; g < gap; g++) expq.push_back(5'b00010);
      end
    end
    expq.push_back(5'b00001);
    expq.push_back(5'b00000);
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b0;
    bus1.start = 1'b1; bus1.pattern_in = 3'b111; bus1.repeat_cnt = 4'd2;
    bus0.start = 1'b1; bus0.pattern_in = 3'b111; bus0.repeat_cnt = 4'd2;
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      got = obs1();
      checks++;
      if (got !== 5'b00000) begin
        errors++; $display("FAIL reset_gap1 cycle %0d: got %b expected 00000", c, got);
      end
      got = obs0();
      checks++;
      if (got !== 5'b00000) begin
        errors++; $display("FAIL reset_gap0 cycle %0d: got %b expected 00000", c, got);
      end
    end
    bus1.start = 1'b0; bus0.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    got = obs1();
    checks++;
    if (got !== 5'b00000) begin
      errors++; $display("FAIL reset_release: got %b expected 00000", got);
    end
  endtask

  task automatic test_single_frame(input string name);
    logic [4:0] got, exp;
    int unsigned cyc = 0;
    expq.delete();
    push_frames(DEFAULT_PATTERN, 1, 1);
    bus1.pattern_in = DEFAULT_PATTERN; bus1.repeat_cnt = 4'd1; bus1.start = 1'b1;
    while (expq.size() > 0) begin
      @(negedge clk);
      bus1.start = 1'b0;
      cyc++;
      exp = expq.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
      end
    end
  endtask

  task automatic test_repeat_gap();
    logic [4:0] got, exp;
    int unsigned cyc = 0, busy_cnt = 0, fs_cnt = 0;
    expq.delete();
    push_frames(3'b110, 3, 1);
    bus1.pattern_in = 3'b110; bus1.repeat_cnt = 4'd3; bus1.start = 1'b1;
    while (expq.size() > 0) begin
      @(negedge clk);
      bus1.start = 1'b0;
      cyc++;
      exp = expq.pop_front();
      got = obs1();
      busy_cnt += got[1];
      fs_cnt   += got[2];
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL repeat_gap cycle %0d: got %b expected %b", cyc, got, exp);
      end
    end
    checks++;
    if (busy_cnt != 11 || fs_cnt != 3) begin
      errors++;
      $display("FAIL repeat_gap_counts: busy=%0d fs=%0d expected busy=11 fs=3", busy_cnt, fs_cnt);
    end
  endtask

  task automatic test_loopback();
    logic [4:0] got, exp;
    int unsigned cyc;
    // GAP=1 instance
    @(negedge clk); det_clear = 1'b1;
    @(negedge clk); det_clear = 1'b0;
    expq.delete();
    push_frames(3'b110, 3, 1);
    bus1.pattern_in = 3'b110; bus1.repeat_cnt = 4'd3; bus1.start = 1'b1;
    cyc = 0;
    while (expq.size() > 0) begin
      @(negedge clk);
      bus1.start = 1'b0;
      cyc++;
      exp = expq.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL loop_gap1 cycle %0d: got %b expected %b", cyc, got, exp);
      end
    end
    checks++;
    if (det1 != 3) begin
      errors++; $display("FAIL loop_gap1_detect: got %0d expected 3", det1);
    end
    // GAP=0 instance: back-to-back frames
    @(negedge clk); det_clear = 1'b1;
    @(negedge clk); det_clear = 1'b0;
    expq.delete();
    push_frames(3'b110, 3, 0);
    bus0.pattern_in = 3'b110; bus0.repeat_cnt = 4'd3; bus0.start = 1'b1;
    cyc = 0;
    while (expq.size() > 0) begin
      @(negedge clk);
      bus0.start = 1'b0;
      cyc++;
      exp = expq.pop_front();
      got = obs0();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL loop_gap0 cycle %0d: got %b expected %b", cyc, got, exp);
      end
    end
    checks++;
    if (det0 != 3) begin
      errors++; $display("FAIL loop_gap0_detect: got %0d expected 3", det0);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    int unsigned cyc = 0;
    expq.delete();
    push_frames(3'b101, 2, 0);
    bus0.pattern_in = 3'b101; bus0.repeat_cnt = 4'd2; bus0.start = 1'b1;
    while (expq.size() > 0) begin
      @(negedge clk);
      bus0.start = 1'b0;
      cyc++;
      exp = expq.pop_front();
      got = obs0();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_repeat_zero();
    logic [4:0] got, exp;
    int unsigned cyc = 0;
    expq.delete();
    push_frames(3'b110, 0, 1);
    expq.push_back(5'b00000);
    bus1.pattern_in = 3'b110; bus1.repeat_cnt = 4'd0; bus1.start = 1'b1;
    while (expq.size() > 0) begin
      @(negedge clk);
      bus1.start = 1'b0;
      cyc++;
      exp = expq.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL repeat_zero cycle %0d: got %b expected %b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [4:0] got, exp;
    int unsigned cyc = 0;
    expq.delete();
    push_frames(3'b110, 2, 1);
    expq.push_back(5'b00000);
    bus1.pattern_in = 3'b110; bus1.repeat_cnt = 4'd2; bus1.start = 1'b1;
    while (expq.size() > 0) begin
      @(negedge clk);
      cyc++;
      exp = expq.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL start_while_busy cycle %0d: got %b expected %b", cyc, got, exp);
      end
      // Keep hammering start through SHIFT/GAP/FINISH, release once idle
      bus1.pattern_in = 3'b101;
      bus1.repeat_cnt = 4'd5;
      bus1.start      = exp[1] | exp[0];
    end
    bus1.start = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] got, exp;
    int unsigned cyc = 0;
    expq.delete();
    push_frames(3'b110, 3, 1);
    bus1.pattern_in = 3'b110; bus1.repeat_cnt = 4'd3; bus1.start = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      cyc++;
      exp = expq.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", cyc, got, exp);
      end
    end
    reset = 1'b0;
    expq.delete();
    for (int unsigned i = 0; i < 5; i++) expq.push_back(5'b00000);
    while (expq.size() > 0) begin
      @(negedge clk);
      reset = 1'b1;
      cyc++;
      exp = expq.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_mid_post cycle %0d: got %b expected %b", cyc, got, exp);
      end
    end
    test_single_frame("after_reset_frame");
  endtask

  initial begin
    bus1.start = 1'b0; bus1.pattern_in = '0; bus1.repeat_cnt = '0;
    bus0.start = 1'b0; bus0.pattern_in = '0; bus0.repeat_cnt = '0;
    test_reset();
    test_single_frame("single_frame");
    test_repeat_gap();
    test_loopback();
    test_back_to_back();
    test_repeat_zero();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
